// File: rtl/kpn_pkg.sv
// Shared KPN channel definitions: token width, default channel depth and a
// constant log2 helper used to size pointers.
package kpn_pkg;

    localparam int KPN_TOKEN_W    = 16;
    localparam int KPN_FIFO_DEPTH = 8;

    typedef logic [KPN_TOKEN_W-1:0] kpn_token_t;

    function automatic int kpn_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/kpn_fifo_mem.sv
// Token storage for the KPN FIFO: one synchronous write port and one
// asynchronous read port so the head token falls through without a request.
module kpn_fifo_mem
    import kpn_pkg::*;
#(
    parameter int WIDTH  = KPN_TOKEN_W,
    parameter int DEPTH  = KPN_FIFO_DEPTH,
    parameter int ADDR_W = kpn_clog2(KPN_FIFO_DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; contents are only meaningful behind the pointers.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/kpn_fifo.sv
// Bounded first-word-fall-through KPN channel with registered full/empty and
// sticky overflow/underflow flags for catching protocol misuse.
module kpn_fifo
    import kpn_pkg::*;
#(
    parameter  int WIDTH  = KPN_TOKEN_W,
    parameter  int DEPTH  = KPN_FIFO_DEPTH,
    localparam int ADDR_W = kpn_clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr,
    input  logic [WIDTH-1:0]  data_in,
    output logic              full,
    input  logic              rd,
    output logic [WIDTH-1:0]  data_out,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              push;
    logic              pop;

    // Requests are qualified by the registered flags, so a rejected access
    // never touches pointers, count or memory.
    assign push = wr & ~full;
    assign pop  = rd & ~empty;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count     <= count_nxt;
            full      <= (count_nxt == CNT_FULL);
            empty     <= (count_nxt == '0);
            overflow  <= overflow | (wr & full);
            underflow <= underflow | (rd & empty);
        end
    end

    kpn_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_kpn_fifo.sv
// Scoreboard bench for kpn_fifo: accepted pushes are queued by a small
// occupancy model and compared against data_out as the consumer pops.
module tb_kpn_fifo;
    import kpn_pkg::*;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] data_in = '0;
    logic        full;
    logic [15:0] data_out;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          mdl_cnt = 0;
    logic        exp_ovf = 1'b0;
    logic        exp_udf = 1'b0;
    logic [15:0] sb[$];
    logic [15:0] exp_tok;

    kpn_fifo dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr        (wr),
        .data_in   (data_in),
        .full      (full),
        .rd        (rd),
        .data_out  (data_out),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "timeout");
    end

    // One clock of stimulus; the reference model tracks what the FIFO should accept.
    task automatic drive(input logic w, input logic r, input logic [15:0] d);
        logic acc_w, acc_r;
        acc_w = w && (mdl_cnt < DEPTH);
        acc_r = r && (mdl_cnt > 0);
        if (w && mdl_cnt == DEPTH) exp_ovf = 1'b1;
        if (r && mdl_cnt == 0) exp_udf = 1'b1;
        @(negedge clock);
        wr = w; rd = r; data_in = d;
        @(posedge clock);
        #1;
        wr = 1'b0; rd = 1'b0;
        if (acc_r && sb.size() > 0) void'(sb.pop_front());
        if (acc_w) sb.push_back(d);
        mdl_cnt = mdl_cnt + (acc_w ? 1 : 0) - (acc_r ? 1 : 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        sb.delete();
        mdl_cnt = 0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if ({empty, full, count, overflow, underflow} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got e=%b f=%b c=%0d o=%b u=%b, want e=1 f=0 c=0 o=0 u=0",
                     empty, full, count, overflow, underflow);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 1'b0, 16'hA5A5);
        n_cmp++;
        if ({empty, count, data_out} !== {1'b0, 4'd1, 16'hA5A5}) begin
            n_fail++;
            $display("FAIL single_push: got e=%b c=%0d d=%h, want e=0 c=1 d=a5a5", empty, count, data_out);
        end
        drive(1'b0, 1'b1, 16'h0);
        n_cmp++;
        if ({empty, count} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL single_pop: got e=%b c=%0d, want e=1 c=0", empty, count);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) drive(1'b1, 1'b0, 16'(i));
        n_cmp++;
        if ({full, count, overflow} !== {1'b1, 4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL fill: got f=%b c=%0d o=%b, want f=1 c=8 o=0", full, count, overflow);
        end
        drive(1'b1, 1'b0, 16'hFFFF);
        n_cmp++;
        if ({full, count, overflow} !== {1'b1, 4'(mdl_cnt), exp_ovf}) begin
            n_fail++;
            $display("FAIL overflow: got f=%b c=%0d o=%b, want f=1 c=%0d o=%b",
                     full, count, overflow, mdl_cnt, exp_ovf);
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp_tok = sb[0];
            n_cmp++;
            if (empty !== 1'b0 || data_out !== exp_tok) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got e=%b d=%h, want e=0 d=%h", i, empty, data_out, exp_tok);
            end
            drive(1'b0, 1'b1, 16'h0);
        end
        n_cmp++;
        if ({empty, full, count} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL drained: got e=%b f=%b c=%0d, want e=1 f=0 c=0", empty, full, count);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(1'b0, 1'b1, 16'h0);
        n_cmp++;
        if ({underflow, empty, count} !== {exp_udf, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL underflow: got u=%b e=%b c=%0d, want u=%b e=1 c=0", underflow, empty, count, exp_udf);
        end
        drive(1'b1, 1'b0, 16'h1234);
        n_cmp++;
        if ({data_out, count} !== {16'h1234, 4'd1}) begin
            n_fail++;
            $display("FAIL udf_ptrs: got d=%h c=%0d, want d=1234 c=1", data_out, count);
        end
        drive(1'b0, 1'b1, 16'h0);
        n_cmp++;
        if ({underflow, empty} !== {1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL udf_sticky: got u=%b e=%b, want u=1 e=1", underflow, empty);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0030 + 16'(i));
        exp_tok = sb[0];
        n_cmp++;
        if (data_out !== exp_tok) begin
            n_fail++;
            $display("FAIL rw_mid_head: got %h want %h", data_out, exp_tok);
        end
        drive(1'b1, 1'b1, 16'h0033);
        n_cmp++;
        if (count !== 4'd3) begin
            n_fail++;
            $display("FAIL rw_mid_count: got %0d want 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            exp_tok = sb[0];
            n_cmp++;
            if (data_out !== exp_tok) begin
                n_fail++;
                $display("FAIL rw_mid_order[%0d]: got %h want %h", i, data_out, exp_tok);
            end
            drive(1'b0, 1'b1, 16'h0);
        end
        drive(1'b1, 1'b1, 16'h0044);
        n_cmp++;
        if ({count, empty, underflow, data_out} !== {4'd1, 1'b0, exp_udf, 16'h0044}) begin
            n_fail++;
            $display("FAIL rw_empty: got c=%0d e=%b u=%b d=%h, want c=1 e=0 u=%b d=0044",
                     count, empty, underflow, data_out, exp_udf);
        end
        for (int i = 0; i < DEPTH - 1; i++) drive(1'b1, 1'b0, 16'h0050 + 16'(i));
        exp_tok = sb[0];
        n_cmp++;
        if ({full, data_out} !== {1'b1, exp_tok}) begin
            n_fail++;
            $display("FAIL rw_full_head: got f=%b d=%h, want f=1 d=%h", full, data_out, exp_tok);
        end
        drive(1'b1, 1'b1, 16'hBEEF);
        n_cmp++;
        if ({count, full, overflow} !== {4'd7, 1'b0, exp_ovf}) begin
            n_fail++;
            $display("FAIL rw_full: got c=%0d f=%b o=%b, want c=7 f=0 o=%b", count, full, overflow, exp_ovf);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            exp_tok = sb[0];
            n_cmp++;
            if (data_out !== exp_tok) begin
                n_fail++;
                $display("FAIL rw_full_order[%0d]: got %h want %h", i, data_out, exp_tok);
            end
            drive(1'b0, 1'b1, 16'h0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b0, 16'h1000);
        drive(1'b1, 1'b0, 16'h1001);
        for (int i = 2; i < 20; i++) begin
            exp_tok = sb[0];
            n_cmp++;
            if (data_out !== exp_tok || count !== 4'd2) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got d=%h c=%0d, want d=%h c=2", i, data_out, count, exp_tok);
            end
            drive(1'b1, 1'b1, 16'h1000 + 16'(i));
        end
        for (int i = 0; i < 2; i++) begin
            exp_tok = sb[0];
            n_cmp++;
            if (data_out !== exp_tok) begin
                n_fail++;
                $display("FAIL wrap_tail[%0d]: got %h want %h", i, data_out, exp_tok);
            end
            drive(1'b0, 1'b1, 16'h0);
        end
        n_cmp++;
        if ({empty, count} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL wrap_end: got e=%b c=%0d, want e=1 c=0", empty, count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b0, 1'b1, 16'h0);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 16'h2000 + 16'(i));
        drive(1'b1, 1'b0, 16'hDEAD);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'h0);
        n_cmp++;
        if ({count, overflow, underflow} !== {4'd5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_areset: got c=%0d o=%b u=%b, want c=5 o=1 u=1", count, overflow, underflow);
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({empty, full, count, overflow, underflow} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got e=%b f=%b c=%0d o=%b u=%b, want e=1 f=0 c=0 o=0 u=0",
                     empty, full, count, overflow, underflow);
        end
        #2;
        reset_n = 1'b1;
        sb.delete();
        mdl_cnt = 0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        drive(1'b1, 1'b0, 16'h7777);
        n_cmp++;
        if ({empty, count, data_out} !== {1'b0, 4'd1, 16'h7777}) begin
            n_fail++;
            $display("FAIL post_areset: got e=%b c=%0d d=%h, want e=0 c=1 d=7777", empty, count, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
